mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one Wishbone-style external bus between the CPU's instruction-fetch port (IF) and its data-memory port (MEM stage).
- Generates per-port stall signals and holds each served result until the pipeline advances.
- Performs byte-lane steering for byte/half/word stores and loads, including sign/zero extension of loaded data.
- Sits between the 5-stage datapath and the system bus; the pipeline controller ORs its stalls into the stage enables.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles to wait for bus_ack before abort (BUS_TIMEOUT_EN only); counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  main clock
rst  input  1  asynchronous active-high reset
advance  input  1  pipeline advances at this edge; clears both done flags
inst_ren  input  1  instruction read request, held stable while inst_stall
inst_addr  input  32  instruction address, word aligned
inst_data  output  32  fetched instruction, valid while inst_done
inst_stall  output  1  IF request pending and not yet served
mem_ren  input  1  data read request
mem_wen  input  1  data write request
mem_type  input  2  0=byte, 1=half, 2=word (3 treated as word)
mem_ext  input  1  1=sign-extend loaded byte/half, 0=zero-extend
mem_addr  input  32  data byte address
mem_dout  input  32  store data, right-aligned
mem_din  output  32  load result, extended, valid while data done
mem_stall  output  1  MEM request pending and not yet served
mem_unalign  output  1  one-cycle pulse: misaligned MEM access rejected
bus_cyc  output  1  bus cycle active
bus_stb  output  1  strobe, equal to bus_cyc
bus_we  output  1  write cycle
bus_addr  output  32  {addr[31:2], 2'b00}
bus_sel  output  4  byte-lane enables, little-endian (lane0 = addr 0)
bus_dout  output  32  write data, lane-replicated
bus_din  input  32  read data
bus_ack  input  1  slave acknowledge

Behaviour:
- Reset (async): state IDLE; all bus_* outputs 0; inst_data, mem_din 0; both done flags 0; mem_unalign 0. Stalls are combinational and equal the raw requests after reset.
- Stalls:
  - inst_stall = inst_ren & ~done_i.
  - mem_stall = (mem_ren | mem_wen) & ~done_m.
  - mem_ren & mem_wen together are treated as a write.
- FSM states: IDLE, DATA, INST.
- IDLE:
  - If a MEM request is pending and aligned: go to DATA and register the bus outputs.
  - Else if a MEM request is pending and misaligned (half with addr[0]=1, or word with addr[1:0]!=0): no bus cycle; set done_m, pulse mem_unalign, mem_din=0.
  - Else if an IF request is pending: go to INST.
  - MEM always has priority over IF.
- DATA/INST: bus_cyc=bus_stb=1 from the first cycle after entry. At the edge where bus_ack=1:
  - Latch the result.
  - Set the port's done flag.
  - Drop cyc/stb.
  - Return to IDLE. There is no back-to-back without an IDLE cycle.
- Minimum latency: request seen in cycle N, bus active in N+1, zero-wait ack in N+1, stall low in N+2.
- Lane steering:
  - Byte: sel = 1<<addr[1:0]; dout = {4{d[7:0]}}.
  - Half: sel = addr[1] ? 4'b1100 : 4'b0011; dout = {2{d[15:0]}}.
  - Word: sel = 4'hF; dout = d.
  - Loads extract the lane selected by addr and extend per mem_ext.
- advance=1 at an edge clears done_i and done_m. Results stay held until then.
- If the request drops mid-cycle (flush): the bus cycle always runs to ack and the result is discarded (done not set).
- If advance and ack occur at the same edge: ack sets done for the new request only when that request is still asserted in the next cycle; otherwise the result is discarded.
- A port whose done flag is set is never re-served before advance.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined: a counter runs while bus_cyc is high. Reaching TIMEOUT_CYCLES without ack:
  - Terminates the cycle.
  - Sets done for the port.
  - Returns 32'hFFFF_FFFF on loads.
  - Adds output bus_timeout, a one-cycle pulse.
- Undefined: no counter, no bus_timeout port; the block waits for ack indefinitely.

Test Plan:
- Zero-wait IF: inst_ren=1, inst_addr=0x100, bus_din=0x2408_0005 acked in the first bus cycle -> bus_addr=0x100, sel=F, we=0; inst_stall high for 2 cycles; inst_data=0x2408_0005; advance clears done.
- Contention: inst_ren and mem_ren (word @0x200) raised together -> DATA cycle first, then INST; mem_stall falls before inst_stall; both results held until advance.
- Byte store: mem_wen, type=0, addr=0x1003, dout=0x0000_00AB -> sel=4'b1000, bus_dout=0xABAB_ABAB, we=1.
- Signed half load: type=1, ext=1, addr=0x2002, bus_din=0x8001_1234 -> sel=4'b1100, mem_din=0xFFFF_8001; with ext=0 -> 0x0000_8001.
- Misaligned word load @0x3001 -> no bus_cyc, mem_unalign pulses once, mem_stall low the next cycle, mem_din=0.
- Reset mid-cycle: assert rst while bus_cyc=1 with 3 wait states -> cyc/stb/we drop immediately, state IDLE, done flags 0; with BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4 and no ack -> bus_timeout pulses after 4 cycles, mem_din=0xFFFF_FFFF.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - IF/MEM arbiter onto one Wishbone-style bus with byte-lane steering
//
// Shares a single external bus between the instruction-fetch port and the
// data-memory port. MEM has priority over IF. Each served result is held,
// with its done flag set, until the pipeline advances.
//
// Optional build macro: BUS_TIMEOUT_EN adds a bus timeout counter
// (TIMEOUT_CYCLES) and the bus_timeout output pulse.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   advance             pipeline advance; clears both done flags
//   inst_ren/inst_addr  IF read request and word address
//   inst_data           fetched instruction (valid while IF done)
//   inst_stall          IF request pending and not yet served
//   mem_ren/mem_wen     MEM read / write request (both high = write)
//   mem_type/mem_ext    access size (0 byte, 1 half, 2/3 word) and sign extend
//   mem_addr/mem_dout   MEM byte address and right-aligned store data
//   mem_din             extended load result (valid while MEM done)
//   mem_stall           MEM request pending and not yet served
//   mem_unalign         one-cycle pulse for a rejected misaligned access
//   bus_*               Wishbone-style master interface
//   bus_timeout         one-cycle timeout pulse (BUS_TIMEOUT_EN only)
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_stall,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [1:0]  mem_type,
    input  logic        mem_ext,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_unalign,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    input  logic        bus_ack
`ifdef BUS_TIMEOUT_EN
    ,
    output logic        bus_timeout
`endif
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_INST = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        done_i_q, done_i_d, done_m_q, done_m_d;
    logic        pend_i_q, pend_i_d, pend_m_q, pend_m_d;
    logic [31:0] inst_data_q, inst_data_d, mem_din_q, mem_din_d;
    logic        unalign_q, unalign_d;
    logic        cyc_q, cyc_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, dout_q, dout_d;
    logic [3:0]  sel_q, sel_d;
    logic [1:0]  ld_type_q, ld_type_d, ld_off_q, ld_off_d;
    logic        ld_ext_q, ld_ext_d;

    logic        mem_req, mem_is_word, mem_is_half, misalign;
    logic        inst_pending, mem_pending;
    logic [3:0]  st_sel;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        bus_done, tmo_fire;

    // inst_addr is word aligned, so its low bits are ignored
    logic unused_bits;
    assign unused_bits = ^{inst_addr[1:0], TIMEOUT_CYCLES[0]};

    assign mem_req     = mem_ren | mem_wen;
    assign mem_is_word = mem_type[1];
    assign mem_is_half = (mem_type == 2'd1);
    assign misalign    = (mem_is_half & mem_addr[0]) |
                         (mem_is_word & (mem_addr[1:0] != 2'b00));

    assign inst_stall  = inst_ren & ~done_i_q;
    assign mem_stall   = mem_req & ~done_m_q;
    // A port whose ack coincided with advance is resolved in IDLE, never re-fetched there
    assign inst_pending = inst_stall & ~pend_i_q;
    assign mem_pending  = mem_stall & ~pend_m_q;

    // Store steering: replicate the right-aligned datum across all lanes
    always_comb begin
        st_sel  = 4'hF;
        st_data = mem_dout;
        if (mem_is_half) begin
            st_sel  = mem_addr[1] ? 4'b1100 : 4'b0011;
            st_data = {2{mem_dout[15:0]}};
        end else if (!mem_is_word) begin
            st_sel  = 4'b0001 << mem_addr[1:0];
            st_data = {4{mem_dout[7:0]}};
        end
    end

    // Load extraction uses the size/offset captured when the cycle started
    always_comb begin
        case (ld_off_q)
            2'd0:    ld_byte = bus_din[7:0];
            2'd1:    ld_byte = bus_din[15:8];
            2'd2:    ld_byte = bus_din[23:16];
            default: ld_byte = bus_din[31:24];
        endcase
        ld_half = ld_off_q[1] ? bus_din[31:16] : bus_din[15:0];
        if (ld_type_q[1]) begin
            ld_val = bus_din;
        end else if (ld_type_q == 2'd1) begin
            ld_val = {{16{ld_ext_q & ld_half[15]}}, ld_half};
        end else begin
            ld_val = {{24{ld_ext_q & ld_byte[7]}}, ld_byte};
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_pulse_q;

    assign tmo_fire = cyc_q & ~bus_ack & (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if (cyc_q & ~bus_ack & ~tmo_fire) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q   <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_pulse_q <= tmo_fire;
        end
    end

    assign bus_timeout = tmo_pulse_q;
`else
    assign tmo_fire = 1'b0;
`endif

    assign bus_done = cyc_q & (bus_ack | tmo_fire);

    always_comb begin
        state_d     = state_q;
        done_i_d    = done_i_q;
        done_m_d    = done_m_q;
        pend_i_d    = 1'b0;
        pend_m_d    = 1'b0;
        inst_data_d = inst_data_q;
        mem_din_d   = mem_din_q;
        unalign_d   = 1'b0;
        cyc_d       = cyc_q;
        we_d        = we_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        dout_d      = dout_q;
        ld_type_d   = ld_type_q;
        ld_ext_d    = ld_ext_q;
        ld_off_d    = ld_off_q;

        if (advance) begin
            done_i_d = 1'b0;
            done_m_d = 1'b0;
        end
        // Result captured at an advance edge counts only if the request is still up now
        if (pend_i_q & inst_ren & ~advance) done_i_d = 1'b1;
        if (pend_m_q & mem_req & ~advance)  done_m_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (mem_pending & misalign) begin
                    done_m_d  = 1'b1;
                    unalign_d = 1'b1;
                    mem_din_d = '0;
                end else if (mem_pending) begin
                    state_d   = S_DATA;
                    cyc_d     = 1'b1;
                    we_d      = mem_wen;
                    addr_d    = {mem_addr[31:2], 2'b00};
                    sel_d     = st_sel;
                    dout_d    = st_data;
                    ld_type_d = mem_type;
                    ld_ext_d  = mem_ext;
                    ld_off_d  = mem_addr[1:0];
                end else if (inst_pending) begin
                    state_d = S_INST;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = {inst_addr[31:2], 2'b00};
                    sel_d   = 4'hF;
                    dout_d  = '0;
                end
            end
            S_DATA: begin
                if (bus_done) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    sel_d   = '0;
                    dout_d  = '0;
                    // A dropped request (flush) discards the result
                    if (advance | mem_req) begin
                        if (!we_q) mem_din_d = tmo_fire ? 32'hFFFF_FFFF : ld_val;
                        if (advance) pend_m_d = 1'b1;
                        else         done_m_d = 1'b1;
                    end
                end
            end
            S_INST: begin
                if (bus_done) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    sel_d   = '0;
                    dout_d  = '0;
                    if (advance | inst_ren) begin
                        inst_data_d = tmo_fire ? 32'hFFFF_FFFF : bus_din;
                        if (advance) pend_i_d = 1'b1;
                        else         done_i_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            done_i_q    <= 1'b0;
            done_m_q    <= 1'b0;
            pend_i_q    <= 1'b0;
            pend_m_q    <= 1'b0;
            inst_data_q <= '0;
            mem_din_q   <= '0;
            unalign_q   <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            sel_q       <= '0;
            dout_q      <= '0;
            ld_type_q   <= '0;
            ld_ext_q    <= 1'b0;
            ld_off_q    <= '0;
        end else begin
            state_q     <= state_d;
            done_i_q    <= done_i_d;
            done_m_q    <= done_m_d;
            pend_i_q    <= pend_i_d;
            pend_m_q    <= pend_m_d;
            inst_data_q <= inst_data_d;
            mem_din_q   <= mem_din_d;
            unalign_q   <= unalign_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            dout_q      <= dout_d;
            ld_type_q   <= ld_type_d;
            ld_ext_q    <= ld_ext_d;
            ld_off_q    <= ld_off_d;
        end
    end

    assign inst_data   = inst_data_q;
    assign mem_din     = mem_din_q;
    assign mem_unalign = unalign_q;
    assign bus_cyc     = cyc_q;
    assign bus_stb     = cyc_q;
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_sel     = sel_q;
    assign bus_dout    = dout_q;
endmodule
